// File: rtl/arith_share_arbiter.sv
// arith_share_arbiter: shares one 2-stage (a+/-b)*c pipeline among NREQ
// requesters. Results carry the issuing requester's id and leave through a
// valid/ready handshake with back-pressure.
// Build option: define FIXED_PRIORITY_EN to replace round-robin arbitration
// with fixed priority (lowest asserted index wins, no pointer register).
module arith_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  input  logic [NREQ*WIDTH-1:0] c_bus,
  input  logic [NREQ-1:0]       s_bus,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_d,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_d_q, out_d_d;
  logic [IDW-1:0]   out_id_q, out_id_d;

  logic             s2_load;
  logic             accept;
  logic             found;
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   start_ptr;
  int               idx;
  logic [WIDTH-1:0] a_sel, b_sel, c_sel;
  logic             s_sel;

`ifdef FIXED_PRIORITY_EN
  // Fixed priority: the search always begins at requester 0.
  assign start_ptr = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  assign start_ptr = ptr_q;
`endif

  assign s2_load = !out_valid_q || out_ready;
  assign accept  = !s1_valid_q || s2_load;

  // Search req starting at start_ptr, wrapping; first asserted request wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // One-hot grant, suppressed while stage 1 cannot take a new operation or in reset.
  always_comb begin
    gnt = '0;
    if (!rst && accept && found) gnt[grant_idx] = 1'b1;
  end

  assign grant_any = |gnt;

  // Mux the granted requester's operands.
  always_comb begin
    a_sel = a_bus[int'(grant_idx)*WIDTH +: WIDTH];
    b_sel = b_bus[int'(grant_idx)*WIDTH +: WIDTH];
    c_sel = c_bus[int'(grant_idx)*WIDTH +: WIDTH];
    s_sel = s_bus[grant_idx];
  end

  // Next-state for both pipeline stages and the round-robin pointer.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_c_d      = s1_c_q;
    s1_id_d     = s1_id_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;
    out_id_d    = out_id_q;
    if (accept) begin
      s1_valid_d = grant_any;
      if (grant_any) begin
        s1_sum_d = s_sel ? (a_sel + b_sel) : (a_sel - b_sel);
        s1_c_d   = c_sel;
        s1_id_d  = grant_idx;
      end
    end
    // Output data only changes when a real result moves in, so it stays put otherwise.
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d_d  = s1_sum_q * s1_c_q;
        out_id_d = s1_id_q;
      end
    end
  end

`ifndef FIXED_PRIORITY_EN
  // Pointer moves to the requester after the one just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = IDW'((int'(grant_idx) + 1) % NREQ);
  end
`endif

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_c_q      <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
      out_id_q    <= '0;
`ifndef FIXED_PRIORITY_EN
      ptr_q       <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_c_q      <= s1_c_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
      out_id_q    <= out_id_d;
`ifndef FIXED_PRIORITY_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_d     = out_d_q;
  assign out_id    = out_id_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_arith_share_arbiter.sv
// Directed bench for arith_share_arbiter. Inputs change 1 ns after the rising
// edge; outputs and grants are checked on the falling edge.
module tb_arith_share_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int I = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req;
  logic [N*W-1:0] a_bus, b_bus, c_bus;
  logic [N-1:0] s_bus;
  logic [N-1:0] gnt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_d;
  logic [I-1:0] out_id;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int gcount;
  int seq[6];
  logic [W-1:0] exp_d[4];

  arith_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(I)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_bus(a_bus), .b_bus(b_bus), .c_bus(c_bus), .s_bus(s_bus),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic s);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
    c_bus[i*W +: W] = c;
    s_bus[i] = s;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '1; a_bus = '0; b_bus = '0; c_bus = '0; s_bus = '0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_d", 32'(out_d), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'(gnt), 0);
    adv();
    chk("rst_gnt_edge", 32'(gnt), 0);
    req = '0;
    rst = 1'b0;

    // Basic add: (3+2)*4 = 0x14
    set_op(0, 8'd3, 8'd2, 8'd4, 1'b1); req = 4'b0001;
    @(negedge clk); chk("add_gnt", 32'(gnt), 32'h1);
    adv(); req = '0;
    @(negedge clk);
    chk("add_gnt_off", 32'(gnt), 0);
    chk("add_ov_early", 32'(out_valid), 0);
    chk("add_busy", 32'(busy), 1);
    adv();
    @(negedge clk);
    chk("add_ov", 32'(out_valid), 1);
    chk("add_d", 32'(out_d), 32'h14);
    chk("add_id", 32'(out_id), 0);
    adv();
    @(negedge clk);
    chk("add_drained", 32'(out_valid), 0);
    chk("add_idle", 32'(busy), 0);

    // Subtract wrap: (2-5)*3 = 0xFD*3 -> 0xF7
    adv();
    set_op(0, 8'd2, 8'd5, 8'd3, 1'b0); req = 4'b0001;
    @(negedge clk); chk("sub_gnt", 32'(gnt), 32'h1);
    adv(); req = '0;
    adv();
    @(negedge clk);
    chk("sub_ov", 32'(out_valid), 1);
    chk("sub_d", 32'(out_d), 32'hF7);
    adv();

    // Pointer is 1 after the grants to 0; req 1100 picks requester 2.
    req = 4'b1100;
    @(negedge clk); chk("ptr_gnt", 32'(gnt), 32'h4);
    adv(); req = '0;
    adv(); adv();
    @(negedge clk); chk("ptr_d", 32'(out_d), 32'h0);
    adv();

    // Fairness from pointer 0
    rst_pulse();
`ifdef FIXED_PRIORITY_EN
    seq = '{0, 0, 0, 0, 0, 0};
`else
    seq = '{0, 1, 2, 3, 0, 1};
`endif
    exp_d = '{8'd4, 8'd6, 8'd8, 8'd10};
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 8'd1, 8'd2, 1'b1);
    req = 4'b1111; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("fair_gnt", 32'(gnt), 32'(1) << seq[n]);
      if (n >= 2) begin
        chk("fair_ov", 32'(out_valid), 1);
        chk("fair_id", 32'(out_id), 32'(seq[n-2]));
        chk("fair_d", 32'(out_d), 32'(exp_d[seq[n-2]]));
      end
      adv();
    end
    req = '0;
    for (int n = 4; n < 6; n++) begin
      @(negedge clk);
      chk("fair_tail_id", 32'(out_id), 32'(seq[n]));
      chk("fair_tail_d", 32'(out_d), 32'(exp_d[seq[n]]));
      adv();
    end
    @(negedge clk); chk("fair_drained", 32'(busy), 0);
    adv();

    // Back-pressure: requester 1 held, consumer stalled for 5 cycles
    set_op(1, 8'd10, 8'd3, 8'd2, 1'b1);
    req = 4'b0010; out_ready = 1'b0; gcount = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (gnt == 4'b0010) gcount++;
      if (n >= 2) begin
        chk("bp_gnt_off", 32'(gnt), 0);
        chk("bp_d_hold", 32'(out_d), 32'h1A);
        chk("bp_id_hold", 32'(out_id), 1);
      end
      adv();
      if (n == 0) set_op(1, 8'd7, 8'd2, 8'd1, 1'b0);
    end
    chk("bp_grants", 32'(gcount), 2);
    out_ready = 1'b1;
    set_op(1, 8'd1, 8'd1, 8'd1, 1'b1);
    @(negedge clk);
    chk("bp_pushpop_gnt", 32'(gnt), 32'h2);
    chk("bp_drain1_d", 32'(out_d), 32'h1A);
    adv(); req = '0;
    @(negedge clk);
    chk("bp_drain2_ov", 32'(out_valid), 1);
    chk("bp_drain2_d", 32'(out_d), 32'h05);
    adv();
    @(negedge clk);
    chk("bp_drain3_ov", 32'(out_valid), 1);
    chk("bp_drain3_d", 32'(out_d), 32'h02);
    adv();
    @(negedge clk);
    chk("bp_idle_ov", 32'(out_valid), 0);
    chk("bp_idle_busy", 32'(busy), 0);
    adv();

    // Reset with both stages full
    set_op(0, 8'd1, 8'd1, 8'd1, 1'b1);
    req = 4'b0001; out_ready = 1'b0;
    adv(); adv();
    @(negedge clk);
    chk("mid_full_ov", 32'(out_valid), 1);
    chk("mid_full_gnt", 32'(gnt), 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_d", 32'(out_d), 0);
    rst = 1'b0;
    req = 4'b1001; out_ready = 1'b1;
    #1;
    chk("mid_post_gnt", 32'(gnt), 32'h1);
    adv(); req = '0;
    adv(); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
